// File: rtl/data_path.sv
// Mini-SRC style 32-bit single-bus datapath: register file, special registers,
// select/encode logic, prioritised bus multiplexer and combinational ALU.
module data_path (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  alu_control,
    input  logic [31:0] Mdatain,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        MDROut,
    input  logic        InPortout,
    input  logic        LOout,
    input  logic        ZHIout,
    input  logic        ZLOout,
    input  logic        Pout,
    input  logic        Cout,
    input  logic        Yout,
    input  logic        IRen,
    input  logic        MARen,
    input  logic        MDRen,
    input  logic        Read,
    input  logic        Write,
    input  logic        Yen,
    input  logic        Pen,
    input  logic        ZHIen,
    input  logic        ZLOen,
    input  logic        HIen,
    input  logic        LOen,
    input  logic        R0en,
    input  logic        R1en,
    input  logic        R2en,
    input  logic        R3en,
    input  logic        R4en,
    input  logic        R5en,
    input  logic        R6en,
    input  logic        R7en,
    input  logic        R8en,
    input  logic        R9en,
    input  logic        R10en,
    input  logic        R11en,
    input  logic        R12en,
    input  logic        R13en,
    input  logic        R14en,
    input  logic        R15en,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        BAout,
    input  logic        ConIn,
    input  logic        Rin,
    input  logic        Rout,
    input  logic [31:0] InPort_in,
    output logic [31:0] BusMuxOut,
    output logic        CON,
    output logic [31:0] MAR_out
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [31:0] regs [16];
    logic [31:0] pc, ir, mar, mdr, y, hi, lo, in_port;
    logic [63:0] z;
    logic        con_q;

    logic [31:0] bus;
    logic [31:0] c_sext;
    logic [63:0] zin;
    logic        con_d;
    logic [3:0]  idx;
    logic [15:0] sel_dec;
    logic [15:0] r_out_v, r_en_v;
    logic [15:0] r_drive, r_load;

    logic [37:0] unused_sigs;
    assign unused_sigs = {Write, ir[31:27], hi};

    // A = Y, B = bus; results narrower than 64 bits leave Zin[63:32] at zero.
    function automatic logic [63:0] alu_eval(input logic [4:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] a64, b64, prod;
        logic signed [31:0] quo, rem;
        logic [63:0]        dbl;
        logic [4:0]         amt;
        sa   = $signed(a);
        sb   = $signed(b);
        a64  = $signed({{32{a[31]}}, a});
        b64  = $signed({{32{b[31]}}, b});
        prod = '0;
        quo  = '0;
        rem  = '0;
        dbl  = '0;
        amt  = b[4:0];
        alu_eval = '0;
        case (op)
            OP_ADD:  alu_eval[31:0] = a + b;
            OP_SUB:  alu_eval[31:0] = a - b;
            OP_AND:  alu_eval[31:0] = a & b;
            OP_OR:   alu_eval[31:0] = a | b;
            OP_SHR:  alu_eval[31:0] = a >> amt;
            OP_SHRA: alu_eval[31:0] = sa >>> amt;
            OP_SHL:  alu_eval[31:0] = a << amt;
            OP_ROR: begin
                dbl = {a, a} >> amt;
                alu_eval[31:0] = dbl[31:0];
            end
            OP_ROL: begin
                dbl = {a, a} << amt;
                alu_eval[31:0] = dbl[63:32];
            end
            OP_MUL: begin
                prod     = a64 * b64;
                alu_eval = prod;
            end
            OP_DIV: begin
                if (b == '0) begin
                    alu_eval = '0;
                end else begin
                    // INT_MIN / -1 wraps to INT_MIN with zero remainder.
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        quo = sa;
                        rem = '0;
                    end else begin
                        quo = sa / sb;
                        rem = sa % sb;
                    end
                    alu_eval = {rem, quo};
                end
            end
            OP_NEG:  alu_eval[31:0] = -b;
            OP_NOT:  alu_eval[31:0] = ~b;
            default: alu_eval = '0;
        endcase
    endfunction

    assign r_out_v = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_en_v  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                      R7en, R6en, R5en, R4en, R3en, R2en, R1en, R0en};

    always_comb begin
        idx = 4'd0;
        if (Gra)
            idx = ir[26:23];
        else if (Grb)
            idx = ir[22:19];
        else if (Grc)
            idx = ir[18:15];
    end

    assign sel_dec = 16'd1 << idx;
    assign r_load  = r_en_v  | ({16{Rin}} & sel_dec);
    assign r_drive = r_out_v | ({16{Rout | BAout}} & sel_dec);
    assign c_sext  = {{13{ir[18]}}, ir[18:0]};

    // Later assignments override earlier ones, so R0 ends up with top priority.
    always_comb begin
        bus = '0;
        if (Yout)      bus = y;
        if (Cout)      bus = c_sext;
        if (Pout)      bus = pc;
        if (ZLOout)    bus = z[31:0];
        if (ZHIout)    bus = z[63:32];
        if (LOout)     bus = lo;
        if (InPortout) bus = in_port;
        if (MDROut)    bus = mdr;
        for (int n = 15; n >= 0; n--) begin
            if (r_drive[n])
                bus = (n == 0 && BAout) ? 32'd0 : regs[n];
        end
    end

    assign zin = alu_eval(alu_control, y, bus);

    always_comb begin
        case (ir[20:19])
            2'b00:   con_d = (bus == '0);
            2'b01:   con_d = (bus != '0);
            2'b10:   con_d = !bus[31] && (bus != '0);
            default: con_d = bus[31];
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int n = 0; n < 16; n++)
                regs[n] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            z       <= '0;
            hi      <= '0;
            lo      <= '0;
            in_port <= '0;
            con_q   <= 1'b0;
        end else begin
            for (int n = 0; n < 16; n++) begin
                if (r_load[n])
                    regs[n] <= bus;
            end
            if (Pen)    pc  <= bus;
            if (IRen)   ir  <= bus;
            if (MARen)  mar <= bus;
            if (MDRen)  mdr <= Read ? Mdatain : bus;
            if (Yen)    y   <= bus;
            if (HIen)   hi  <= bus;
            if (LOen)   lo  <= bus;
            if (ZLOen)  z[31:0]  <= zin[31:0];
            if (ZHIen)  z[63:32] <= zin[63:32];
            if (ConIn)  con_q    <= con_d;
            in_port <= InPort_in;
        end
    end

    assign BusMuxOut = bus;
    assign CON       = con_q;
    assign MAR_out   = mar;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus pushes expected bus/CON/MAR values,
// a negedge monitor pops and compares them.
module tb_data_path;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [1:0] SEL_BUS = 2'd0;
    localparam logic [1:0] SEL_CON = 2'd1;
    localparam logic [1:0] SEL_MAR = 2'd2;

    logic        clk;
    logic        clr;
    logic [4:0]  alu_control;
    logic [31:0] Mdatain, InPort_in;
    logic [15:0] r_out, r_en;
    logic        MDROut, InPortout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
    logic        IRen, MARen, MDRen, Read, Write;
    logic        Yen, Pen, ZHIen, ZLOen, HIen, LOen;
    logic        Gra, Grb, Grc, BAout, ConIn, Rin, Rout;
    logic [31:0] bus_w, mar_w;
    logic        con_w;

    typedef struct packed {
        logic [1:0]  sel;
        logic [95:0] name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    logic obs;
    int   n_checks;
    int   n_fail;

    data_path dut (
        .clk(clk), .clr(clr), .alu_control(alu_control), .Mdatain(Mdatain),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .MDROut(MDROut), .InPortout(InPortout), .LOout(LOout), .ZHIout(ZHIout),
        .ZLOout(ZLOout), .Pout(Pout), .Cout(Cout), .Yout(Yout),
        .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Read(Read), .Write(Write),
        .Yen(Yen), .Pen(Pen), .ZHIen(ZHIen), .ZLOen(ZLOen), .HIen(HIen), .LOen(LOen),
        .R0en(r_en[0]), .R1en(r_en[1]), .R2en(r_en[2]), .R3en(r_en[3]),
        .R4en(r_en[4]), .R5en(r_en[5]), .R6en(r_en[6]), .R7en(r_en[7]),
        .R8en(r_en[8]), .R9en(r_en[9]), .R10en(r_en[10]), .R11en(r_en[11]),
        .R12en(r_en[12]), .R13en(r_en[13]), .R14en(r_en[14]), .R15en(r_en[15]),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .ConIn(ConIn),
        .Rin(Rin), .Rout(Rout), .InPort_in(InPort_in),
        .BusMuxOut(bus_w), .CON(con_w), .MAR_out(mar_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (obs) begin
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.sel)
                    SEL_CON: act = {31'd0, con_w};
                    SEL_MAR: act = mar_w;
                    default: act = bus_w;
                endcase
                n_checks++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %0s: got %h, expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic idle();
        clr = 1'b0; alu_control = 5'd0; r_out = '0; r_en = '0;
        MDROut = 0; InPortout = 0; LOout = 0; ZHIout = 0; ZLOout = 0;
        Pout = 0; Cout = 0; Yout = 0; IRen = 0; MARen = 0; MDRen = 0;
        Read = 0; Write = 0; Yen = 0; Pen = 0; ZHIen = 0; ZLOen = 0;
        HIen = 0; LOen = 0; Gra = 0; Grb = 0; Grc = 0; BAout = 0;
        ConIn = 0; Rin = 0; Rout = 0; obs = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check(input logic [1:0] sel, input logic [95:0] name, input logic [31:0] val);
        sb.push_back('{sel: sel, name: name, val: val});
        obs = 1'b1;
        cycle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDRen = 1'b1;
        cycle();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        MDROut = 1'b1; IRen = 1'b1;
        cycle();
    endtask

    logic [4:0]  ops    [12];
    logic [31:0] exp_lo [12];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Mdatain  = '0;
        InPort_in = '0;
        idle();
        cycle();

        // Reset with many enables active: clr must win.
        clr = 1'b1; Mdatain = 32'hA5A5_0001; Read = 1; MDRen = 1; r_en = 16'hFFFF;
        Yen = 1; MARen = 1; Pen = 1; ZLOen = 1; ZHIen = 1; LOen = 1; IRen = 1; ConIn = 1;
        alu_control = OP_NOT; InPort_in = 32'hDEAD_BEEF;
        cycle();
        InPortout = 1; check(SEL_BUS, "rst_inport", 32'h0);
        check(SEL_BUS, "rst_bus", 32'h0);
        check(SEL_CON, "rst_con", 32'h0);
        check(SEL_MAR, "rst_mar", 32'h0);
        MDROut = 1; check(SEL_BUS, "rst_mdr", 32'h0);
        Yout = 1;   check(SEL_BUS, "rst_y", 32'h0);
        ZLOout = 1; check(SEL_BUS, "rst_zlo", 32'h0);
        ZHIout = 1; check(SEL_BUS, "rst_zhi", 32'h0);
        LOout = 1;  check(SEL_BUS, "rst_lo", 32'h0);
        r_out[7] = 1; check(SEL_BUS, "rst_r7", 32'h0);
        InPortout = 1; check(SEL_BUS, "inport", 32'hDEAD_BEEF);

        // Fetch
        load_mdr(32'h0000_0077);
        MDROut = 1; MARen = 1; cycle();
        check(SEL_MAR, "mar_77", 32'h77);
        Pout = 1; MARen = 1; cycle();
        check(SEL_MAR, "fetch_mar", 32'h0);
        load_mdr(32'h6228_0005);
        MDROut = 1; check(SEL_BUS, "fetch_mdr", 32'h6228_0005);
        MDROut = 1; IRen = 1; cycle();
        Cout = 1; check(SEL_BUS, "ir_csext", 32'h5);

        // addi R4,R5,5
        load_mdr(32'h10);
        MDROut = 1; r_en[5] = 1; cycle();
        Grb = 1; Rout = 1; Yen = 1; cycle();
        Yout = 1; check(SEL_BUS, "addi_y", 32'h10);
        Cout = 1; alu_control = OP_ADD; ZLOen = 1; cycle();
        ZLOout = 1; Gra = 1; Rin = 1; cycle();
        ZLOout = 1;   check(SEL_BUS, "addi_z", 32'h15);
        r_out[4] = 1; check(SEL_BUS, "addi_r4", 32'h15);
        r_out[5] = 1; check(SEL_BUS, "addi_r5", 32'h10);

        // mul/div with Y=-6, B=4
        load_mdr(32'hFFFF_FFFA);
        MDROut = 1; Yen = 1; cycle();
        load_mdr(32'h4);
        MDROut = 1; alu_control = OP_MUL; ZLOen = 1; ZHIen = 1; cycle();
        ZHIout = 1; check(SEL_BUS, "mul_hi", 32'hFFFF_FFFF);
        ZLOout = 1; check(SEL_BUS, "mul_lo", 32'hFFFF_FFE8);
        MDROut = 1; alu_control = OP_DIV; ZLOen = 1; ZHIen = 1; cycle();
        ZLOout = 1; check(SEL_BUS, "div_quo", 32'hFFFF_FFFF);
        ZHIout = 1; check(SEL_BUS, "div_rem", 32'hFFFF_FFFE);

        // ALU ops with Y=0x80000011, B=4; ZHI starts nonzero from the div
        ops    = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
                   OP_SHL, OP_ROR, OP_ROL, OP_NEG, 5'b00000, OP_NOT};
        exp_lo = '{32'h8000_0015, 32'h8000_000D, 32'h0000_0000, 32'h8000_0015,
                   32'h0800_0001, 32'hF800_0001, 32'h0000_0110, 32'h1800_0001,
                   32'h0000_0118, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFB};
        load_mdr(32'h8000_0011);
        MDROut = 1; Yen = 1; cycle();
        load_mdr(32'h4);
        for (int i = 0; i < 12; i++) begin
            MDROut = 1; alu_control = ops[i]; ZLOen = 1; ZHIen = 1; cycle();
            ZLOout = 1; check(SEL_BUS, "alu_lo", exp_lo[i]);
            ZHIout = 1; check(SEL_BUS, "alu_hi", 32'h0);
        end

        // Divide by zero after loading Z with a nonzero product
        load_mdr(32'h7);
        MDROut = 1; Yen = 1; cycle();
        load_mdr(32'hFFFF_FFFF);
        MDROut = 1; alu_control = OP_MUL; ZLOen = 1; ZHIen = 1; cycle();
        ZLOout = 1; check(SEL_BUS, "mul7_lo", 32'hFFFF_FFF9);
        load_mdr(32'h0);
        MDROut = 1; alu_control = OP_DIV; ZLOen = 1; ZHIen = 1; cycle();
        ZLOout = 1; check(SEL_BUS, "div0_lo", 32'h0);
        ZHIout = 1; check(SEL_BUS, "div0_hi", 32'h0);

        // LO register and negative C sign extension
        load_mdr(32'h1234);
        MDROut = 1; LOen = 1; cycle();
        LOout = 1; check(SEL_BUS, "lo", 32'h1234);
        load_ir(32'h0004_0003);
        Cout = 1; check(SEL_BUS, "csext_neg", 32'hFFFC_0003);

        // BAout: R0 reads as zero
        load_mdr(32'h55);
        MDROut = 1; r_en[0] = 1; cycle();
        load_ir(32'h0);
        Grb = 1; BAout = 1; check(SEL_BUS, "baout_r0", 32'h0);
        Grb = 1; Rout = 1;  check(SEL_BUS, "rout_r0", 32'h55);

        // CON conditions
        load_ir(32'h0018_0000);
        load_mdr(32'h8000_0000);
        MDROut = 1; ConIn = 1; cycle();
        check(SEL_CON, "con_neg", 32'h1);
        load_ir(32'h0);
        load_mdr(32'h1);
        MDROut = 1; ConIn = 1; cycle();
        check(SEL_CON, "con_zero", 32'h0);
        load_ir(32'h0008_0000);
        MDROut = 1; ConIn = 1; cycle();
        check(SEL_CON, "con_nz", 32'h1);
        load_ir(32'h0010_0000);
        load_mdr(32'h8000_0000);
        MDROut = 1; ConIn = 1; cycle();
        check(SEL_CON, "con_pos_n", 32'h0);
        load_mdr(32'h5);
        MDROut = 1; ConIn = 1; cycle();
        check(SEL_CON, "con_pos", 32'h1);

        // clr mid-sequence discards the pending transfer
        load_mdr(32'h99);
        MDROut = 1; Yen = 1; clr = 1; cycle();
        Yout = 1;   check(SEL_BUS, "clr_y", 32'h0);
        MDROut = 1; check(SEL_BUS, "clr_mdr", 32'h0);
        check(SEL_CON, "clr_con", 32'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Mini-SRC style 32-bit register-transfer datapath. It has a single shared bus, sixteen general registers, the special registers (PC, IR, MAR, MDR, Y, Z, HI, LO, in-port), a C-constant sign extender, select-and-encode logic and a combinational ALU. Every transfer is driven by external one-hot control strobes from the control-unit FSM or testbench. Memory sits outside the block: read data enters on `Mdatain`, and the address is MAR.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock; all registers.
- `clr`  in  1  reset; synchronous, active-high.
- `alu_control`  in  5  ALU operation select.
- `Mdatain`  in  32  memory read data.
- `R0out`..`R15out`  in  1 each  drive Rn onto bus.
- `MDROut`, `InPortout`, `LOout`, `ZHIout`, `ZLOout`, `Pout`, `Cout`, `Yout`  in  1 each  drive MDR / in-port / LO / Z[63:32] / Z[31:0] / PC / C-sign-ext / Y onto bus.
- `IRen`, `MARen`, `MDRen`  in  1 each  load IR / MAR / MDR.
- `Read`  in  1  MDR input mux: 1 = `Mdatain`, 0 = bus.
- `Write`  in  1  memory write strobe; no internal effect.
- `Yen`, `Pen`, `ZHIen`, `ZLOen`, `HIen`, `LOen`  in  1 each  load Y / PC / Z[63:32] / Z[31:0] / HI / LO.
- `R0en`..`R15en`  in  1 each  load Rn from bus.
- `Gra`, `Grb`, `Grc`  in  1 each  select IR[26:23] / IR[22:19] / IR[18:15] as the register index.
- `BAout`  in  1  base-address read: selected register onto bus, R0 reads as 0.
- `ConIn`  in  1  load CON flip-flop.
- `Rin`, `Rout`  in  1 each  load / drive the register chosen by Gra/Grb/Grc.
- `InPort_in`  in  32  external in-port data.
- `BusMuxOut`  out  32  current bus value.
- `CON`  out  1  branch-condition flip-flop.
- `MAR_out`  out  32  MAR contents (memory address).

Trailing ports `InPort_in`, `BusMuxOut`, `CON` and `MAR_out` follow `Rout` in the port list, in that order.

## Operation
- **Select/encode**
  - Index = IR[26:23] if Gra, else IR[22:19] if Grb, else IR[18:15] if Grc, else 0.
  - Effective Rn load = `Rnen` | (`Rin` & index==n).
  - Effective Rn drive = `Rnout` | ((`Rout`|`BAout`) & index==n).
- **Bus**
  - Priority encoder, highest first: R0..R15, HI-less specials in the order MDR, in-port, LO, ZHI, ZLO, PC, C, Y.
  - No driver → bus = 0.
  - R0 driven while `BAout`=1 → bus = 0.
- **C sign-extension:** {{13{IR[18]}}, IR[18:0]}.
- **In-port register:** loads `InPort_in` every clock.
- **ALU**
  - Inputs: A = Y, B = bus. Output: 64-bit Zin.
  - 00011 add, 00100 sub (A−B), 00101 and, 00110 or: Zin[31:0] = result, Zin[63:32] = 0 (mod 2^32).
  - 00111 shr (logical, B[4:0]), 01000 shra, 01001 shl, 01010 ror, 01011 rol: shift amount B[4:0].
  - 01111 mul: signed 32×32 → Zin[63:0].
  - 10000 div: signed; Zin[31:0] = quotient, Zin[63:32] = remainder. B=0 → Zin = 0.
  - 10001 neg: −B. 10010 not: ~B.
  - Any other code → Zin = 0.
- **Z loads:** `ZLOen` loads Z[31:0] ← Zin[31:0]; `ZHIen` loads Z[63:32] ← Zin[63:32].
- **MDR:** on `MDRen`, loads `Mdatain` if `Read`, else bus.
- **CON:** on `ConIn`, evaluated from IR[20:19] against the bus.
  - 00: bus==0.
  - 01: bus!=0.
  - 10: bus[31]==0 and bus!=0.
  - 11: bus[31]==1.

## Timing
- Every register loads on the rising `clk` edge when its enable is high. The load source is the combinational bus or mux value settled before that edge.
- The bus, ALU, sign-extension and select logic are purely combinational. An op completes in zero cycles and Z captures it at the next edge.
- Single-cycle transfers: register → bus → destination register in one clock.
- `clr`=1 at an edge zeroes all registers (R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, in-port, CON) and overrides every enable at that edge.
  - After reset: `BusMuxOut`=0, `CON`=0, `MAR_out`=0.
  - `clr` asserted mid-sequence discards any pending transfer.
- Two enables for the same register in one cycle load it once, from the bus.
- A register driven onto the bus and loaded in the same cycle gets the old value via the bus (read-before-write).

## Test plan
- **Reset:** drive arbitrary enables with `clr`=1 for one edge → all registers 0, `BusMuxOut`=0, `CON`=0.
- **Fetch:** PC=0, `Pout`+`MARen` → MAR=0. Then `Mdatain`=32'h62280005 with `Read`+`MDRen` → MDR=32'h62280005. Then `MDROut`+`IRen` → IR=32'h62280005.
- **addi R4,R5,5:** R5=32'h10 preloaded via MDR→`R5en`. Grb+Rout+Yen → Y=32'h10. Cout, `alu_control`=00011, ZLOen → Z[31:0]=32'h15. ZLOout+Gra+Rin → R4=32'h15, R5 unchanged.
- **mul/div:** Y=−6, B=4. mul → Z=64'hFFFFFFFF_FFFFFFE8. div → ZLO=32'hFFFFFFFF (−1), ZHI=32'hFFFFFFFE (−2). Y=7, B=0 div → Z=0.
- **BAout:** IR[22:19]=0, R0=32'h55, Grb+BAout → bus=0. Grb+Rout → bus=32'h55.
- **CON:** IR[20:19]=11, bus=32'h80000000, ConIn → CON=1. IR[20:19]=00, bus=1 → CON=0.
